// File: rtl/sc_lastregbackg_sequencer_pkg.sv
// Shared encodings for the last-row background-type register sequencer:
// FSM state codes, shift-selection codes and the level-to-direction helper.
package sc_lastregbackg_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_SHIFT   = 3'd4,
    S_FINAL   = 3'd5,
    S_LEVELUP = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Even levels scroll the row left, odd levels scroll it right.
  function automatic logic [1:0] shift_for_level(input logic [1:0] lvl);
    return lvl[0] ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/sc_lastregbackg_sequencer_if.sv
// Bundle between game-level controller, sequencer and the last-row register.
// master = stimulus/controller side, slave = the sequencer itself.
interface sc_lastregbackg_sequencer_if;
  logic       start_InLow;
  logic       abort_InLow;
  logic       tick_In;
  logic       goal_In;
  logic       clear_OutLow;
  logic       load_OutLow;
  logic [1:0] shiftselection_Out;
  logic [1:0] transitioncounter_OutBUS;
  logic       loadfinal_OutLow;
  logic       done_Out;

  modport master (
    output start_InLow, abort_InLow, tick_In, goal_In,
    input  clear_OutLow, load_OutLow, shiftselection_Out,
           transitioncounter_OutBUS, loadfinal_OutLow, done_Out
  );

  modport slave (
    input  start_InLow, abort_InLow, tick_In, goal_In,
    output clear_OutLow, load_OutLow, shiftselection_Out,
           transitioncounter_OutBUS, loadfinal_OutLow, done_Out
  );
endinterface

// File: rtl/sc_lastregbackg_sequencer_tickdivider.sv
// Counts accepted prescaler ticks modulo SHIFT_PERIOD; tc flags the tick
// that completes a period (counter at SHIFT_PERIOD-1).
module sc_tickdivider #(
  parameter int SHIFT_PERIOD  = 4,
  parameter int TICKCNT_WIDTH = 4
) (
  input  logic SC_LastRegBACKGTYPE_CLOCK_50,
  input  logic SC_LastRegBACKGTYPE_RESET_InHigh,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [TICKCNT_WIDTH-1:0] LAST = TICKCNT_WIDTH'(SHIFT_PERIOD - 1);

  logic [TICKCNT_WIDTH-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
    if (SC_LastRegBACKGTYPE_RESET_InHigh) cnt <= '0;
    else if (clr)                         cnt <= '0;
    else if (en)                          cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sc_lastregbackg_sequencer.sv
// Moore sequencer for the Frogger last-row background-type register:
// clear, load, tick-paced shifting and goal-driven level advance.
module sc_lastregbackg_sequencer
  import sc_lastregbackg_sequencer_pkg::*;
#(
  parameter int SHIFT_PERIOD  = 4,
  parameter int TICKCNT_WIDTH = 4,
  parameter int NUM_LEVELS    = 4
) (
  input  logic                          SC_LastRegBACKGTYPE_CLOCK_50,
  input  logic                          SC_LastRegBACKGTYPE_RESET_InHigh,
  sc_lastregbackg_sequencer_if.slave    bus
);
  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);

  state_t     state, state_n;
  logic [1:0] level, level_n;
  logic       goal_pend, goal_pend_n;
  logic       div_clr, div_en, div_tc;

  sc_tickdivider #(
    .SHIFT_PERIOD  (SHIFT_PERIOD),
    .TICKCNT_WIDTH (TICKCNT_WIDTH)
  ) u_div (
    .SC_LastRegBACKGTYPE_CLOCK_50     (SC_LastRegBACKGTYPE_CLOCK_50),
    .SC_LastRegBACKGTYPE_RESET_InHigh (SC_LastRegBACKGTYPE_RESET_InHigh),
    .clr                              (div_clr),
    .en                               (div_en),
    .tc                               (div_tc)
  );

  always_comb begin
    state_n     = state;
    level_n     = level;
    goal_pend_n = goal_pend;
    div_clr     = 1'b0;
    div_en      = 1'b0;
    if (!bus.abort_InLow) begin
      state_n     = S_IDLE;
      level_n     = '0;
      goal_pend_n = 1'b0;
      div_clr     = 1'b1;
    end else begin
      case (state)
        S_IDLE:  if (!bus.start_InLow) state_n = S_CLEAR;
        S_CLEAR: begin
          level_n = '0;
          state_n = S_LOAD;
          if (bus.goal_In) goal_pend_n = 1'b1;
        end
        S_LOAD: begin
          div_clr = 1'b1;
          state_n = S_RUN;
          if (bus.goal_In) goal_pend_n = 1'b1;
        end
        S_RUN: begin
          // Goal wins over a coincident tick; that tick is simply dropped.
          if (bus.goal_In || goal_pend) begin
            state_n     = S_FINAL;
            goal_pend_n = 1'b0;
            div_clr     = 1'b1;
          end else if (bus.tick_In) begin
            div_en = 1'b1;
            if (div_tc) state_n = S_SHIFT;
          end
        end
        S_SHIFT: begin
          state_n = S_RUN;
          if (bus.goal_In) goal_pend_n = 1'b1;
        end
        S_FINAL:   state_n = (level == LAST_LEVEL) ? S_DONE : S_LEVELUP;
        S_LEVELUP: begin
          if (level != LAST_LEVEL) level_n = level + 2'd1;
          state_n = S_LOAD;
        end
        S_DONE:  if (!bus.start_InLow) state_n = S_CLEAR;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they belong to while staying glitch-free toward the register.
  always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
    if (SC_LastRegBACKGTYPE_RESET_InHigh) begin
      state                        <= S_IDLE;
      level                        <= '0;
      goal_pend                    <= 1'b0;
      bus.clear_OutLow             <= 1'b1;
      bus.load_OutLow              <= 1'b1;
      bus.shiftselection_Out       <= SHIFT_HOLD;
      bus.transitioncounter_OutBUS <= '0;
      bus.loadfinal_OutLow         <= 1'b1;
      bus.done_Out                 <= 1'b0;
    end else begin
      state                        <= state_n;
      level                        <= level_n;
      goal_pend                    <= goal_pend_n;
      bus.clear_OutLow             <= (state_n != S_CLEAR);
      bus.load_OutLow              <= (state_n != S_LOAD);
      bus.shiftselection_Out       <= (state_n == S_SHIFT) ? shift_for_level(level_n) : SHIFT_HOLD;
      bus.transitioncounter_OutBUS <= level_n;
      bus.loadfinal_OutLow         <= (state_n != S_FINAL);
      bus.done_Out                 <= (state_n == S_DONE);
    end
  end
endmodule
